// File: rtl/mel_energy_accum.sv
// mel_energy_accum: applies triangular mel weights to power bins and accumulates one energy per filter.
// Optional MEL_ACC_SAT_EN: accumulator adds saturate at 2^ACC_W-1 instead of wrapping.
module mel_energy_accum #(
    parameter int NUM_FILT = 26,
    parameter int PWR_W    = 32,
    parameter int ACC_W    = 44
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_valid,
    output logic             pwr_ready,
    input  logic [PWR_W-1:0] pwr_data,
    input  logic [9:0]       pwr_weight,
    input  logic             pwr_last,
    input  logic             pwr_sof,
    input  logic             pwr_eof,
    output logic             mel_valid,
    input  logic             mel_ready,
    output logic [ACC_W-1:0] mel_data,
    output logic [5:0]       mel_idx,
    output logic             mel_eof,
    output logic             acc_ovf
);
    localparam int         PW     = PWR_W + 1;
    localparam logic [5:0] K_LAST = 6'(NUM_FILT - 1);

    logic             stall;
    logic [9:0]       w_lo;
    logic [PWR_W+9:0] lo_prod, hi_prod;
    logic [PW-1:0]    lo_d, hi_d, lo_q, hi_q;
    logic [8:0]       lo_unused, hi_unused;
    logic             s1_v_q, s1_sof_q, s1_last_q, s1_eof_q;

    logic [ACC_W-1:0] cur_q, cur_d, nxt_q, nxt_d, cur_base, nxt_base, cur_new, nxt_new;
    logic [ACC_W:0]   cur_sum, nxt_sum;
    logic [5:0]       k_q, k_d, k_eff;
    logic             done_q, done_d, ovf_q, ovf_d, run, emit, fin;
    logic             em_v_q, em_v_d, em_eof_q, em_eof_d;
    logic [ACC_W-1:0] em_data_q, em_data_d;
    logic [5:0]       em_idx_q, em_idx_d;

    logic             mel_valid_q, mel_eof_q;
    logic [ACC_W-1:0] mel_data_q;
    logic [5:0]       mel_idx_q;

    // A full output register freezes the whole pipeline.
    assign stall     = mel_valid_q & ~mel_ready;
    assign pwr_ready = ~stall;

    assign w_lo    = 10'd512 - pwr_weight;
    assign lo_prod = {{PWR_W{1'b0}}, w_lo} * {10'd0, pwr_data};
    assign hi_prod = {{PWR_W{1'b0}}, pwr_weight} * {10'd0, pwr_data};
    assign {lo_d, lo_unused} = lo_prod;
    assign {hi_d, hi_unused} = hi_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_eof_q  <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else if (!stall) begin
            s1_v_q    <= pwr_valid;
            s1_sof_q  <= pwr_sof;
            s1_last_q <= pwr_last;
            s1_eof_q  <= pwr_eof;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

    // A sof bin discards prior contents, so it accumulates onto zero at filter 0.
    assign cur_base = s1_sof_q ? '0 : cur_q;
    assign nxt_base = s1_sof_q ? '0 : nxt_q;
    assign k_eff    = s1_sof_q ? 6'd0 : k_q;
    assign cur_sum  = {1'b0, cur_base} + {{(ACC_W + 1 - PW){1'b0}}, lo_q};
    assign nxt_sum  = {1'b0, nxt_base} + {{(ACC_W + 1 - PW){1'b0}}, hi_q};
`ifdef MEL_ACC_SAT_EN
    assign cur_new  = cur_sum[ACC_W] ? '1 : cur_sum[ACC_W-1:0];
    assign nxt_new  = nxt_sum[ACC_W] ? '1 : nxt_sum[ACC_W-1:0];
`else
    assign cur_new  = cur_sum[ACC_W-1:0];
    assign nxt_new  = nxt_sum[ACC_W-1:0];
`endif
    assign run  = s1_v_q & (s1_sof_q | ~done_q);
    assign emit = s1_last_q | s1_eof_q;
    assign fin  = s1_eof_q | (k_eff == K_LAST);

    always_comb begin
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        k_d       = k_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        em_v_d    = 1'b0;
        em_data_d = em_data_q;
        em_idx_d  = em_idx_q;
        em_eof_d  = em_eof_q;
        if (run) begin
            cur_d     = emit ? (fin ? '0 : nxt_new) : cur_new;
            nxt_d     = emit ? '0 : nxt_new;
            k_d       = emit ? (fin ? 6'd0 : k_eff + 6'd1) : k_eff;
            done_d    = emit & fin;
            ovf_d     = (ovf_q & ~s1_sof_q) | cur_sum[ACC_W] | nxt_sum[ACC_W];
            em_v_d    = emit;
            em_data_d = emit ? cur_new : em_data_q;
            em_idx_d  = emit ? k_eff : em_idx_q;
            em_eof_d  = emit ? fin : em_eof_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= '0;
            nxt_q     <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            em_v_q    <= 1'b0;
            em_data_q <= '0;
            em_idx_q  <= '0;
            em_eof_q  <= 1'b0;
        end else if (!stall) begin
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            k_q       <= k_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            em_v_q    <= em_v_d;
            em_data_q <= em_data_d;
            em_idx_q  <= em_idx_d;
            em_eof_q  <= em_eof_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mel_valid_q <= 1'b0;
            mel_data_q  <= '0;
            mel_idx_q   <= '0;
            mel_eof_q   <= 1'b0;
        end else if (!stall) begin
            mel_valid_q <= em_v_q;
            mel_data_q  <= em_v_q ? em_data_q : mel_data_q;
            mel_idx_q   <= em_v_q ? em_idx_q : mel_idx_q;
            mel_eof_q   <= em_v_q ? em_eof_q : mel_eof_q;
        end
    end

    assign mel_valid = mel_valid_q;
    assign mel_data  = mel_data_q;
    assign mel_idx   = mel_idx_q;
    assign mel_eof   = mel_eof_q;
    assign acc_ovf   = ovf_q;
endmodule

// File: tb/tb_mel_energy_accum.sv
// tb_mel_energy_accum: directed bins with hand-computed mel energies checked through a scoreboard queue.
module tb_mel_energy_accum;
    typedef struct {
        logic [43:0] data;
        logic [5:0]  idx;
        logic        eof;
    } exp_t;

    localparam logic [43:0] S_SUM = 44'd19327352824;
`ifdef MEL_ACC_SAT_EN
    localparam logic [43:0] OVF_EXP = 44'hFFF_FFFF_FFFF;
`else
    localparam logic [43:0] OVF_EXP = 44'h000_FFFF_EFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwr_valid = 1'b0, pwr_ready, pwr_last = 1'b0, pwr_sof = 1'b0, pwr_eof = 1'b0;
    logic [31:0] pwr_data = '0;
    logic [9:0]  pwr_weight = '0;
    logic        mel_valid, mel_ready = 1'b1, mel_eof, acc_ovf;
    logic [43:0] mel_data;
    logic [5:0]  mel_idx;

    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mel_energy_accum dut (
        .clk(clk), .rst_n(rst_n),
        .pwr_valid(pwr_valid), .pwr_ready(pwr_ready), .pwr_data(pwr_data),
        .pwr_weight(pwr_weight), .pwr_last(pwr_last), .pwr_sof(pwr_sof), .pwr_eof(pwr_eof),
        .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_data(mel_data),
        .mel_idx(mel_idx), .mel_eof(mel_eof), .acc_ovf(acc_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [43:0] d, input logic [5:0] i, input logic e);
        exp_t x;
        x.data = d;
        x.idx  = i;
        x.eof  = e;
        sb.push_back(x);
    endtask

    task automatic send(input logic [31:0] p, input logic [9:0] w, input logic l, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        pwr_valid = 1'b1; pwr_data = p; pwr_weight = w; pwr_last = l; pwr_sof = s; pwr_eof = e;
        #1;
        while (!pwr_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!pwr_ready) begin
            chk("send_timeout_pwr_ready", pwr_ready, 1);
            pwr_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pwr_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && mel_valid && mel_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_output: got idx=%0d data=%0h expected no output", mel_idx, mel_data);
            end else begin
                e = sb.pop_front();
                chk("mel_data", mel_data, e.data);
                chk("mel_idx", mel_idx, e.idx);
                chk("mel_eof", mel_eof, e.eof);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mel_valid", mel_valid, 0);
        chk("rst_pwr_ready", pwr_ready, 1);
        chk("rst_mel_data", mel_data, 0);
        chk("rst_mel_idx", mel_idx, 0);
        chk("rst_mel_eof", mel_eof, 0);
        chk("rst_acc_ovf", acc_ovf, 0);
        rst_n = 1'b1;

        send(32'd1000, 10'd256, 0, 1, 0);
        push_exp(44'd500, 6'd0, 0);
        send(32'd1000, 10'd512, 1, 0, 0);
        idle();
        #1 chk("latency_t0", mel_valid, 0);
        @(negedge clk);
        #1 chk("latency_t1", mel_valid, 0);
        @(negedge clk);
        #1 chk("latency_t2", mel_valid, 1);
        push_exp(44'd3548, 6'd1, 1);
        send(32'd2048, 10'd0, 1, 0, 1);
        wait_empty();

        @(negedge clk);
        mel_ready = 1'b0;
        push_exp(44'd10, 6'd0, 0);
        send(32'd10, 10'd0, 1, 1, 0);
        push_exp(44'd20, 6'd1, 0);
        send(32'd20, 10'd0, 1, 0, 0);
        push_exp(44'd30, 6'd2, 0);
        send(32'd30, 10'd0, 1, 0, 0);
        idle();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("stall_pwr_ready", pwr_ready, 0);
            chk("stall_mel_data", mel_data, 10);
            chk("stall_mel_valid", mel_valid, 1);
        end
        @(negedge clk);
        mel_ready = 1'b1;
        wait_empty();

        push_exp(44'd100, 6'd0, 0);
        send(32'd100, 10'd0, 0, 1, 0);
        send(32'd100, 10'd512, 1, 0, 0);
        push_exp(44'd300, 6'd1, 0);
        send(32'd200, 10'd0, 1, 0, 0);
        push_exp(44'd20, 6'd2, 1);
        send(32'd41, 10'd256, 0, 0, 1);
        send(32'd999, 10'd0, 1, 0, 0);
        push_exp(44'd7, 6'd0, 0);
        send(32'd7, 10'd0, 1, 1, 0);
        wait_empty();

        for (int k = 0; k < 26; k++) begin
            for (int i = 0; i < 9; i++) begin
                if (i == 8) push_exp(k == 0 ? S_SUM : 2 * S_SUM, 6'(k), k == 25);
                send(32'hFFFF_FFFF, 10'(64 * i), i == 8, k == 0 && i == 0, 0);
            end
        end
        for (int i = 0; i < 23; i++) send(32'hFFFF_FFFF, 10'(i * 20), i % 3 == 0, 0, 0);
        wait_empty();
        repeat (4) idle();
        chk("frame_done_no_output", mel_valid, 0);

        for (int i = 0; i < 4097; i++) begin
            if (i == 4096) begin
                chk("acc_ovf_before_wrap", acc_ovf, 0);
                push_exp(OVF_EXP, 6'd0, 0);
            end
            send(32'hFFFF_FFFF, 10'd0, i == 4096, i == 0, 0);
        end
        wait_empty();
        chk("acc_ovf_set", acc_ovf, 1);
        push_exp(44'd5, 6'd0, 0);
        send(32'd5, 10'd0, 1, 1, 0);
        wait_empty();
        chk("acc_ovf_cleared_by_sof", acc_ovf, 0);

        @(negedge clk);
        mel_ready = 1'b0;
        send(32'd5, 10'd0, 1, 1, 0);
        for (int n = 0; n < 10 && !mel_valid; n++) begin
            @(negedge clk);
            pwr_valid = 1'b0;
            #1;
        end
        chk("pre_reset_mel_valid", mel_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mel_valid", mel_valid, 0);
        chk("async_rst_pwr_ready", pwr_ready, 1);
        chk("async_rst_mel_data", mel_data, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mel_ready = 1'b1;
        push_exp(44'd77, 6'd0, 0);
        send(32'd77, 10'd0, 1, 1, 0);
        wait_empty();

        repeat (3) idle();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
